// File: rtl/eq_compare_seq.sv
// Push-button equality comparator front end: synchronises and debounces two
// buttons, sequences capture of operand A then B, and registers the result.
module eq_compare_seq #(
   parameter int WIDTH     = 4,
   parameter int DB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             push1,
   input  logic             push2,
   output logic             eq,
   output logic             eq_valid,
   output logic             a_loaded,
   output logic             seq_err,
   output logic [1:0]       dbg_state,
   output logic [WIDTH-1:0] dbg_reg_a,
   output logic [WIDTH-1:0] dbg_reg_b
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] A_LOADED = 2'd1;
   localparam logic [1:0] DONE     = 2'd2;

   // Bit 0 carries push1, bit 1 carries push2 through the whole front end.
   logic [1:0]         raw;
   logic [1:0]         sync0;
   logic [1:0]         sync1;
   logic [1:0]         db;
   logic [1:0]         db_d;
   logic [1:0][CW-1:0] cnt;
   logic [1:0]         press;
   logic               p1;
   logic               p2;

   logic [1:0]         state;
   logic [WIDTH-1:0]   reg_a;
   logic [WIDTH-1:0]   reg_b;

   assign raw = {push2, push1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0 <= '0;
         sync1 <= '0;
         db    <= '0;
         db_d  <= '0;
         cnt   <= '0;
      end else begin
         sync0 <= raw;
         sync1 <= sync0;
         db_d  <= db;
         for (int i = 0; i < 2; i++) begin
            // Accept a new level only after DB_CYCLES consecutive differing samples.
            if (sync1[i] != db[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  db[i]  <= sync1[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CW'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   assign press = db & ~db_d;
   assign p1    = press[0];
   assign p2    = press[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         reg_a    <= '0;
         reg_b    <= '0;
         eq       <= 1'b0;
         eq_valid <= 1'b0;
         seq_err  <= 1'b0;
      end else begin
         seq_err <= 1'b0;
         case (state)
            IDLE: begin
               if (p1) begin
                  reg_a <= in;
                  state <= A_LOADED;
               end
               // With no A held, any B press is rejected, alone or alongside p1.
               if (p2) seq_err <= 1'b1;
            end
            A_LOADED: begin
               if (p1) begin
                  reg_a <= in;
               end else if (p2) begin
                  reg_b    <= in;
                  eq       <= (in == reg_a);
                  eq_valid <= 1'b1;
                  state    <= DONE;
               end
               if (p1 && p2) seq_err <= 1'b1;
            end
            DONE: begin
               if (p1) begin
                  reg_a    <= in;
                  eq_valid <= 1'b0;
                  state    <= A_LOADED;
               end else if (p2) begin
                  reg_b <= in;
                  eq    <= (in == reg_a);
               end
               if (p1 && p2) seq_err <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign a_loaded  = (state == A_LOADED) || (state == DONE);
   assign dbg_state = state;
   assign dbg_reg_a = reg_a;
   assign dbg_reg_b = reg_b;

endmodule

// File: tb/tb_eq_compare_seq.sv
// Bench for eq_compare_seq: window-based debounce model plus sequencing model,
// compared every cycle, with directed literal checks around the key scenarios.
module tb_eq_compare_seq;

   localparam int W  = 4;
   localparam int DB = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in_v;
   logic         push1;
   logic         push2;
   logic         eq;
   logic         eq_valid;
   logic         a_loaded;
   logic         seq_err;
   logic [1:0]   dbg_state;
   logic [W-1:0] dbg_reg_a;
   logic [W-1:0] dbg_reg_b;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic         m_db   [2];
   logic         m_pend [2];
   logic         m_pipe [2][2];
   logic         m_hist [2][DB];
   logic         m_have_a;
   logic         m_valid;
   logic         m_eq;
   logic         m_err;
   logic [W-1:0] m_reg_a;
   logic [W-1:0] m_reg_b;

   eq_compare_seq #(.WIDTH(W), .DB_CYCLES(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in_v),
      .push1     (push1),
      .push2     (push2),
      .eq        (eq),
      .eq_valid  (eq_valid),
      .a_loaded  (a_loaded),
      .seq_err   (seq_err),
      .dbg_state (dbg_state),
      .dbg_reg_a (dbg_reg_a),
      .dbg_reg_b (dbg_reg_b)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_db[b]      = 1'b0;
         m_pend[b]    = 1'b0;
         m_pipe[b][0] = 1'b0;
         m_pipe[b][1] = 1'b0;
         for (int i = 0; i < DB; i++) m_hist[b][i] = 1'b0;
      end
      m_have_a = 1'b0;
      m_valid  = 1'b0;
      m_eq     = 1'b0;
      m_err    = 1'b0;
      m_reg_a  = '0;
      m_reg_b  = '0;
   endtask

   // One clock edge of the model: act on presses recognised at the previous
   // edge, then update the debounced levels from the 2-edge-delayed raw input.
   task automatic model_step(input logic r1, input logic r2, input logic [W-1:0] v);
      logic rw [2];
      logic seen;
      logic all_diff;
      logic p1;
      logic p2;
      rw[0] = r1;
      rw[1] = r2;
      p1 = m_pend[0];
      p2 = m_pend[1];
      m_err = p2 && (p1 || !m_have_a);
      if (p1) begin
         m_reg_a  = v;
         m_have_a = 1'b1;
         m_valid  = 1'b0;
      end else if (p2 && m_have_a) begin
         m_reg_b = v;
         m_eq    = (v == m_reg_a);
         m_valid = 1'b1;
      end
      for (int b = 0; b < 2; b++) begin
         seen         = m_pipe[b][0];
         m_pipe[b][0] = m_pipe[b][1];
         m_pipe[b][1] = rw[b];
         for (int i = 0; i < DB - 1; i++) m_hist[b][i] = m_hist[b][i+1];
         m_hist[b][DB-1] = seen;
         all_diff = 1'b1;
         for (int i = 0; i < DB; i++) if (m_hist[b][i] == m_db[b]) all_diff = 1'b0;
         m_pend[b] = 1'b0;
         if (all_diff) begin
            m_db[b]   = ~m_db[b];
            m_pend[b] = m_db[b];
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step(push1, push2, in_v);
         #1;
         if (rst_n) begin
            check("eq", eq, m_eq);
            check("eq_valid", eq_valid, m_valid);
            check("a_loaded", a_loaded, m_have_a);
            check("seq_err", seq_err, m_err);
            check("reg_a", dbg_reg_a, m_reg_a);
            check("reg_b", dbg_reg_b, m_reg_b);
         end
      end
   endtask

   task automatic set_btn(input int b, input logic lvl);
      if (b == 0) push1 = lvl;
      else if (b == 1) push2 = lvl;
      else begin
         push1 = lvl;
         push2 = lvl;
      end
   endtask

   task automatic press(input int b, input logic [W-1:0] v);
      @(negedge clk);
      in_v = v;
      set_btn(b, 1'b1);
      repeat (DB + 4) @(negedge clk);
      set_btn(b, 1'b0);
      repeat (DB + 4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_eq"}, eq, 1'b0);
      check({name, "_eq_valid"}, eq_valid, 1'b0);
      check({name, "_a_loaded"}, a_loaded, 1'b0);
      check({name, "_seq_err"}, seq_err, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      push1 = 1'b0;
      push2 = 1'b0;
      in_v  = '0;
      model_reset();
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      check("reset_state", dbg_state, 2'd0);
      rst_n = 1'b1;

      // Mismatch, with exact press latency on push2
      press(0, 4'b0100);
      check("mm_a_loaded", a_loaded, 1'b1);
      check("mm_valid_pre", eq_valid, 1'b0);
      @(negedge clk);
      in_v  = 4'b1000;
      push2 = 1'b1;
      repeat (DB + 2) @(posedge clk);
      #1 check("mm_valid_edge6", eq_valid, 1'b0);
      @(posedge clk);
      #1 check("mm_valid_edge7", eq_valid, 1'b1);
      check("mm_eq", eq, 1'b0);
      @(negedge clk);
      push2 = 1'b0;
      repeat (DB + 4) @(negedge clk);

      // Match and overwrite
      press(0, 4'b0110);
      press(1, 4'b0110);
      check("match_eq", eq, 1'b1);
      check("match_valid", eq_valid, 1'b1);
      press(0, 4'b1111);
      check("ovr_valid", eq_valid, 1'b0);
      check("ovr_a_loaded", a_loaded, 1'b1);
      press(1, 4'b1111);
      check("ovr_eq", eq, 1'b1);
      press(1, 4'b0011);
      check("reb_eq", eq, 1'b0);
      check("reb_valid", eq_valid, 1'b1);

      // push2 from IDLE is rejected with a single-cycle pulse
      do_reset();
      @(negedge clk);
      push2 = 1'b1;
      repeat (DB + 2) @(posedge clk);
      #1 check("idle_p2_err_pre", seq_err, 1'b0);
      @(posedge clk);
      #1 check("idle_p2_err", seq_err, 1'b1);
      check("idle_p2_a_loaded", a_loaded, 1'b0);
      @(posedge clk);
      #1 check("idle_p2_err_end", seq_err, 1'b0);
      @(negedge clk);
      push2 = 1'b0;
      repeat (DB + 4) @(negedge clk);

      // Both buttons on the same edge from IDLE
      in_v = 4'b0101;
      push1 = 1'b1;
      push2 = 1'b1;
      repeat (DB + 3) @(posedge clk);
      #1 check("both_a_loaded", a_loaded, 1'b1);
      check("both_err", seq_err, 1'b1);
      check("both_valid", eq_valid, 1'b0);
      check("both_reg_a", dbg_reg_a, 4'b0101);
      @(posedge clk);
      #1 check("both_err_end", seq_err, 1'b0);
      @(negedge clk);
      push1 = 1'b0;
      push2 = 1'b0;
      repeat (DB + 4) @(negedge clk);

      // Bounce on push1, then a long hold with `in` wandering
      do_reset();
      in_v  = 4'b1001;
      push1 = 1'b1;
      repeat (3) @(negedge clk);
      push1 = 1'b0;
      repeat (2) @(negedge clk);
      push1 = 1'b1;
      repeat (DB + 2) @(posedge clk);
      #1 check("bounce_none_yet", a_loaded, 1'b0);
      @(posedge clk);
      #1 check("bounce_capture", a_loaded, 1'b1);
      check("bounce_reg_a", dbg_reg_a, 4'b1001);
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         in_v = W'($urandom);
      end
      push1 = 1'b0;
      repeat (DB + 4) @(negedge clk);
      press(1, 4'b1001);
      check("bounce_hold_eq", eq, 1'b1);

      // Reset mid-debounce, released with push1 held
      @(negedge clk);
      in_v  = 4'b0011;
      push1 = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1 check_all_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (DB + 2) @(posedge clk);
      #1 check("rst_rel_none", a_loaded, 1'b0);
      @(posedge clk);
      #1 check("rst_rel_capture", a_loaded, 1'b1);
      check("rst_rel_reg_a", dbg_reg_a, 4'b0011);
      @(negedge clk);
      push1 = 1'b0;
      repeat (DB + 4) @(negedge clk);

      // Reset in DONE with eq=1, asserted between edges
      press(1, 4'b0011);
      check("rst_done_eq", eq, 1'b1);
      @(negedge clk);
      #5 rst_n = 1'b0;
      #1 check_all_zero("rst_done");
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised presses with bounce, simultaneous presses and a wandering bus
      for (int n = 0; n < 40; n++) begin
         int b;
         int nb;
         b  = int'($urandom_range(0, 2));
         nb = int'($urandom_range(0, 2));
         for (int k = 0; k < nb; k++) begin
            set_btn(b, 1'b1);
            repeat ($urandom_range(1, DB - 1)) begin
               @(negedge clk);
               in_v = W'($urandom);
            end
            set_btn(b, 1'b0);
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               in_v = W'($urandom);
            end
         end
         set_btn(b, 1'b1);
         repeat ($urandom_range(DB + 3, DB + 10)) begin
            @(negedge clk);
            in_v = ($urandom_range(0, 1) == 1) ? W'($urandom) : in_v;
         end
         set_btn(b, 1'b0);
         repeat ($urandom_range(DB + 3, DB + 8)) begin
            @(negedge clk);
            in_v = W'($urandom);
         end
      end

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eq_compare_seq.md
# eq_compare_seq

Sequencer and front end for the push-button equality comparator. Two raw push buttons (`push1`, `push2`) and a shared `in` switch bus feed the block. It synchronises and debounces each button, turns presses into single-cycle events and sequences capture of operand A then operand B. It then presents a registered equality result with a valid flag. It sits between the board I/O pins and the result LED, replacing direct button-to-register wiring.

## Interface
- `WIDTH`, default 4: operand width.
- `DB_CYCLES`, default 4: number of consecutive cycles a synchronised button level must differ from the debounced level before it is accepted (≥1).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in` input WIDTH: operand value from switches, sampled at capture.
- `push1` input 1: raw, asynchronous, bouncing button; a press captures operand A.
- `push2` input 1: raw, asynchronous, bouncing button; a press captures operand B.
- `eq` output 1: registered, 1 when captured A equals captured B.
- `eq_valid` output 1: 1 while `eq` reflects the current A/B pair.
- `a_loaded` output 1: 1 when operand A holds a captured value.
- `seq_err` output 1: single-cycle pulse on a rejected press.

## Operation
- Each button passes through a 2-flop synchroniser, then a debouncer.
- Each debouncer has a counter 0..DB_CYCLES-1.
  - When the synchronised level ≠ debounced level: the counter increments. On the cycle it would reach DB_CYCLES, the debounced level flips and the counter clears.
  - When the levels are equal: the counter clears.
- Press event = debounced rising edge (debounced & ~debounced_d), high exactly one cycle. Release generates no event.
- FSM states and transitions (p1/p2 = press events):
  - IDLE: p1 → capture `in` into reg_a → A_LOADED. p2 alone → `seq_err` pulse, stay.
  - A_LOADED: p1 → recapture reg_a, stay. p2 → capture `in` into reg_b, eq <= (`in` == reg_a), `eq_valid` <= 1 → DONE.
  - DONE: p1 → recapture reg_a, `eq_valid` <= 0 → A_LOADED. p2 → recapture reg_b, recompute eq, stay.
- Simultaneous p1 and p2 in the same cycle: p1 is honoured per the current state, p2 is dropped, and `seq_err` pulses.
- `a_loaded` = state ∈ {A_LOADED, DONE}.
- Comparison is full WIDTH bits, unsigned bitwise equality.
- `eq` holds its last value when `eq_valid` is 0. Consumers must qualify `eq` with `eq_valid`.
- Unused FSM encoding → IDLE on the next edge.

## Timing
- Reset (async assert, sync-safe release): state IDLE; reg_a, reg_b, synchronisers, debounced levels, debounced_d and counters all 0; `eq`=0, `eq_valid`=0, `a_loaded`=0, `seq_err`=0.
- Press latency: count edge 0 as the first edge sampling the raw button high, with the button stable high. Then:
  - sync out = 1 after edge 1;
  - debounced = 1 after edge DB_CYCLES+1;
  - press event is high during the following cycle;
  - state, registers and outputs update on edge DB_CYCLES+2.
  - Total: DB_CYCLES+3 edges. With the default, the 7th edge.
- A bounce or glitch shorter than DB_CYCLES synchronised cycles produces no event. Any return to the debounced level restarts the count.
- Holding a button produces exactly one event. A re-press needs a debounced release first, i.e. DB_CYCLES stable low cycles.
- A button held high through reset release is treated as a fresh press, with the same latency counted from the first post-reset edge.
- `in` is sampled only on the capture edge and may change at any other time.
- `seq_err` is high for exactly one cycle, aligned with the rejected event's capture edge.
- `rst_n` asserted mid-sequence returns the block to the reset state immediately, with no clock required. A partially counted debounce is discarded.

## Test plan
- Mismatch: DB_CYCLES=4, 20 ns clock. Press push1 with in=0100, release, then press push2 with in=1000 → `a_loaded`=1 after the 1st press; after the 2nd, `eq_valid`=1, `eq`=0, exactly 7 edges after push2 is first sampled high.
- Match and overwrite: A=0110, B=0110 → `eq`=1, `eq_valid`=1. Press push1 with in=1111 → `eq_valid`=0, `a_loaded`=1. Press push2 with in=1111 → `eq`=1. Press push2 again with in=0011 → `eq`=0, still `eq_valid`=1.
- Bounce: on push1 apply a 3-cycle high, 2-cycle low, 3-cycle high, then stable high → exactly one capture, none before the stable segment completes DB_CYCLES. Hold 10000 cycles → no further events.
- Ordering: press push2 from IDLE → `seq_err` one-cycle pulse, state IDLE, `a_loaded`=0. Both buttons rise on the same edge in IDLE → A captured, `seq_err` pulses once, `eq_valid`=0.
- Reset: assert `rst_n`=0 mid-debounce and in DONE with `eq`=1 → all outputs 0 asynchronously. Release with push1 held → one capture DB_CYCLES+3 edges later.
